line_word_seq: RTL and testbench
================================

LINE_WORD_SEQ -- requirements
Module: line_word_seq

Interface
REQ-001: Parameter LINELEN, default 512, cache line width in bits.
REQ-002: Parameter WORDLEN, default 64, output word width in bits; multiple of MUXINTERVAL, at most LINELEN.
REQ-003: Parameter MUXINTERVAL, default 16, word alignment granule in bits. Derived: SLOTS=LINELEN/MUXINTERVAL, STEP=WORDLEN/MUXINTERVAL, IDXW=$clog2(SLOTS).
REQ-004: The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005: Port clk, input, 1, rising-edge clock.
REQ-006: Port reset_n, input, 1, asynchronous active-low reset.
REQ-007: Port Start, input, 1, begin a stream at StartIdx; honoured only in IDLE.
REQ-008: Port StartIdx, input, IDXW, starting granule index within the first line.
REQ-009: Port Stop, input, 1, abort the stream and return to IDLE.
REQ-010: Port LineIn, input, LINELEN, line data from the cache array or bus.
REQ-011: Port LineInValid, input, 1, LineIn is valid.
REQ-012: Port LineInReady, output, 1, block accepts a line this cycle.
REQ-013: Port Word, output, WORDLEN, current word; granule 0 in the LSBs.
REQ-014: Port WordValid, output, 1, Word is valid.
REQ-015: Port WordReady, input, 1, consumer accepts Word.
REQ-016: Port WordSpill, output, 1, Word is assembled from two lines; valid only with WordValid.

Function
REQ-017: The block SHALL implement states IDLE, FILL, STREAM, SPILLFILL, SPILL, and hold registers CurLine, NextLine and Idx (IDXW+1 bits).
REQ-018: IDLE: Start SHALL load Idx=StartIdx and go to FILL next cycle; all outputs 0.
REQ-019: FILL: LineInReady=1; on LineInValid, CurLine<=LineIn and go to STREAM.
REQ-020: STREAM with Idx+STEP<=SLOTS: WordValid=1, Word=CurLine[Idx*MUXINTERVAL +: WORDLEN], WordSpill=0.
REQ-021: STREAM with Idx+STEP>SLOTS: the block SHALL go to SPILLFILL without asserting WordValid.
REQ-022: STREAM handshake (WordValid&WordReady): Idx<=Idx+STEP; when the result equals SLOTS, Idx<=0 and go to FILL.
REQ-023: SPILLFILL: LineInReady=1; on LineInValid, NextLine<=LineIn and go to SPILL.
REQ-024: SPILL: WordValid=1, WordSpill=1, Word = upper (SLOTS-Idx) granules of CurLine in the LSBs, followed by the lowest (Idx+STEP-SLOTS) granules of NextLine.
REQ-025: SPILL handshake: CurLine<=NextLine, Idx<=Idx+STEP-SLOTS, go to STREAM.
REQ-026: Once asserted, WordValid, Word and WordSpill SHALL hold stable until the handshake completes (no retraction except by Stop or reset).
REQ-027: Latency SHALL be one cycle from line acceptance to WordValid, and one word per cycle in STREAM under continuous WordReady.
REQ-028: LineInReady SHALL be 1 only in FILL and SPILLFILL; LineInValid in any other state SHALL be ignored.
REQ-029: Stop SHALL take priority over every transition: the next state is IDLE, and WordValid/LineInReady are 0 from the next cycle. Stop with Start in the same cycle means IDLE.
REQ-030: Start outside IDLE SHALL be ignored.
REQ-031: A simultaneous LineInValid and Stop in FILL or SPILLFILL SHALL discard the line.
REQ-032: Granule index arithmetic SHALL use IDXW+1 bits so that Idx+STEP never overflows.

Reset
REQ-033: Asserting reset_n=0 SHALL immediately force IDLE, Idx=0, LineInReady=0, WordValid=0, WordSpill=0 and Word=0, including mid-stream or mid-spill.
REQ-034: CurLine and NextLine SHALL reset to 0.
REQ-035: The first Start after deassertion SHALL behave identically to the first Start after power-up.

Verification (LINELEN=128, WORDLEN=32, MUXINTERVAL=16: SLOTS=8, STEP=2)
REQ-036: Start, StartIdx=0, line L0, WordReady=1 -> Word = L0[31:0], L0[63:32], L0[95:64], L0[127:96] on consecutive cycles, then LineInReady=1 (FILL).
REQ-037: Start, StartIdx=7, line L0, then L1 -> WordSpill=1 and Word={L1[15:0], L0[127:112]}; the next word is L1[47:16].
REQ-038: Backpressure: WordReady=0 for 5 cycles in STREAM -> Word and WordValid remain constant and Idx is unchanged.
REQ-039: Stop asserted in SPILLFILL with LineInValid=1 -> IDLE next cycle, no word emitted, and a subsequent Start works normally.
REQ-040: reset_n pulsed low in SPILL with WordValid=1 -> all outputs 0 asynchronously, and state is IDLE after release.
REQ-041: Start while in STREAM -> ignored, and the word sequence continues unchanged.

Source files
------------

// File: rtl/line_word_seq.sv
// line_word_seq: slices a stream of cache lines into WORDLEN-bit words that
// start on any MUXINTERVAL-bit granule. A word that runs off the end of the
// current line is assembled from the tail of that line and the head of the next.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. LineInReady depends only on state (never on LineInValid). Once
// WordValid rises, Word/WordSpill/WordValid hold until WordReady is seen,
// unless Stop or reset aborts the stream.
module line_word_seq #(
    parameter int LINELEN     = 512,
    parameter int WORDLEN     = 64,
    parameter int MUXINTERVAL = 16
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        Start,
    input  logic [$clog2(LINELEN/MUXINTERVAL)-1:0]      StartIdx,
    input  logic                                        Stop,
    input  logic [LINELEN-1:0]                          LineIn,
    input  logic                                        LineInValid,
    output logic                                        LineInReady,
    output logic [WORDLEN-1:0]                          Word,
    output logic                                        WordValid,
    input  logic                                        WordReady,
    output logic                                        WordSpill,
    output logic [2:0]                                  dbg_state
);

    localparam int SLOTS = LINELEN / MUXINTERVAL;
    localparam int STEP  = WORDLEN / MUXINTERVAL;
    localparam int IDXW  = $clog2(SLOTS);
    // One extra bit so idx + STEP never wraps.
    localparam logic [IDXW:0] SLOTS_I = (IDXW+1)'(SLOTS);
    localparam logic [IDXW:0] STEP_I  = (IDXW+1)'(STEP);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_STREAM    = 3'd2,
        S_SPILLFILL = 3'd3,
        S_SPILL     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [LINELEN-1:0]   cur_q, cur_d;
    logic [LINELEN-1:0]   nxt_q, nxt_d;
    logic [IDXW:0]        idx_q, idx_d;
    logic [IDXW:0]        idx_sum;
    logic [MUXINTERVAL-1:0] gran [2*SLOTS];
    logic [WORDLEN-1:0]   word_mux;

    assign dbg_state = state_q;
    assign idx_sum   = idx_q + STEP_I;

    // Granule view of {NextLine, CurLine}: spill words are just a window
    // that crosses from the lower half into the upper half.
    for (genvar g = 0; g < SLOTS; g++) begin : g_gran
        assign gran[g]         = cur_q[g*MUXINTERVAL +: MUXINTERVAL];
        assign gran[SLOTS + g] = nxt_q[g*MUXINTERVAL +: MUXINTERVAL];
    end

    // Word window of STEP granules starting at idx, granule 0 in the LSBs.
    for (genvar i = 0; i < STEP; i++) begin : g_word
        logic [IDXW:0] sel;
        assign sel = idx_q + (IDXW+1)'(i);
        assign word_mux[i*MUXINTERVAL +: MUXINTERVAL] = gran[sel];
    end

    // State, line buffers and granule index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            nxt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state, register updates and outputs; Stop overrides everything.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        idx_d       = idx_q;
        LineInReady = 1'b0;
        WordValid   = 1'b0;
        WordSpill   = 1'b0;
        Word        = '0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    idx_d   = {1'b0, StartIdx};
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                LineInReady = 1'b1;
                if (LineInValid) begin
                    cur_d   = LineIn;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (idx_sum > SLOTS_I) begin
                    // Word straddles the line end: fetch the next line first.
                    state_d = S_SPILLFILL;
                end else begin
                    WordValid = 1'b1;
                    Word      = word_mux;
                    if (WordReady) begin
                        if (idx_sum == SLOTS_I) begin
                            idx_d   = '0;
                            state_d = S_FILL;
                        end else begin
                            idx_d = idx_sum;
                        end
                    end
                end
            end
            S_SPILLFILL: begin
                LineInReady = 1'b1;
                if (LineInValid) begin
                    nxt_d   = LineIn;
                    state_d = S_SPILL;
                end
            end
            S_SPILL: begin
                WordValid = 1'b1;
                WordSpill = 1'b1;
                Word      = word_mux;
                if (WordReady) begin
                    cur_d   = nxt_q;
                    idx_d   = idx_sum - SLOTS_I;
                    state_d = S_STREAM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (Stop) begin
            // Abort: any line offered this cycle is discarded.
            state_d = S_IDLE;
            cur_d   = cur_q;
            nxt_d   = nxt_q;
            idx_d   = idx_q;
        end
    end

endmodule

// File: tb/tb_line_word_seq.sv
// Bench for line_word_seq with 128-bit lines, 32-bit words, 16-bit granules.
module tb_line_word_seq;

    localparam int LINELEN     = 128;
    localparam int WORDLEN     = 32;
    localparam int MUXINTERVAL = 16;
    localparam int SLOTS       = LINELEN / MUXINTERVAL;
    localparam int STEP        = WORDLEN / MUXINTERVAL;
    localparam int IDXW        = $clog2(SLOTS);

    logic                 clk;
    logic                 reset_n;
    logic                 Start;
    logic [IDXW-1:0]      StartIdx;
    logic                 Stop;
    logic [LINELEN-1:0]   LineIn;
    logic                 LineInValid;
    logic                 LineInReady;
    logic [WORDLEN-1:0]   Word;
    logic                 WordValid;
    logic                 WordReady;
    logic                 WordSpill;
    logic [2:0]           dbg_state;

    int checks;
    int errors;

    line_word_seq #(
        .LINELEN(LINELEN),
        .WORDLEN(WORDLEN),
        .MUXINTERVAL(MUXINTERVAL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .Start(Start),
        .StartIdx(StartIdx),
        .Stop(Stop),
        .LineIn(LineIn),
        .LineInValid(LineInValid),
        .LineInReady(LineInReady),
        .Word(Word),
        .WordValid(WordValid),
        .WordReady(WordReady),
        .WordSpill(WordSpill),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINELEN-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic go_idle();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        LineInValid = 1'b0;
        WordReady = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        Start = 1'b0; StartIdx = '0; Stop = 1'b0;
        LineIn = '0; LineInValid = 1'b0; WordReady = 1'b0;
        tick(); tick();
        checks++;
        if (LineInReady !== 1'b0 || WordValid !== 1'b0 || WordSpill !== 1'b0 || Word !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b spill=%b word=%h want all 0",
                     LineInReady, WordValid, WordSpill, Word);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (LineInReady !== 1'b0 || WordValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got rdy=%b vld=%b want 0 0", LineInReady, WordValid);
        end
    endtask

    task automatic test_aligned();
        logic [LINELEN-1:0] l0;
        l0 = rand_line();
        WordReady = 1'b1;
        Start = 1'b1; StartIdx = '0; tick(); Start = 1'b0;
        checks++;
        if (LineInReady !== 1'b1) begin
            errors++;
            $display("FAIL aligned_fill_ready got %b want 1", LineInReady);
        end
        LineIn = l0; LineInValid = 1'b1; tick(); LineInValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (WordValid !== 1'b1 || WordSpill !== 1'b0 || Word !== l0[k*WORDLEN +: WORDLEN]) begin
                errors++;
                $display("FAIL aligned_word%0d got vld=%b spill=%b word=%h want 1 0 %h",
                         k, WordValid, WordSpill, Word, l0[k*WORDLEN +: WORDLEN]);
            end
            tick();
        end
        checks++;
        if (LineInReady !== 1'b1 || WordValid !== 1'b0) begin
            errors++;
            $display("FAIL aligned_refill got rdy=%b vld=%b want 1 0", LineInReady, WordValid);
        end
        go_idle();
        checks++;
        if (LineInReady !== 1'b0) begin
            errors++;
            $display("FAIL aligned_stop_idle got rdy=%b want 0", LineInReady);
        end
    endtask

    task automatic test_spill();
        logic [LINELEN-1:0] l0, l1;
        logic [WORDLEN-1:0] exp_w;
        l0 = rand_line(); l1 = rand_line();
        WordReady = 1'b1;
        Start = 1'b1; StartIdx = IDXW'(7); tick(); Start = 1'b0;
        LineIn = l0; LineInValid = 1'b1; tick();
        // Line offered during the bubble cycle must be ignored.
        LineIn = rand_line();
        checks++;
        if (WordValid !== 1'b0 || LineInReady !== 1'b0) begin
            errors++;
            $display("FAIL spill_bubble got vld=%b rdy=%b want 0 0", WordValid, LineInReady);
        end
        tick();
        checks++;
        if (LineInReady !== 1'b1 || WordValid !== 1'b0) begin
            errors++;
            $display("FAIL spill_fill_ready got rdy=%b vld=%b want 1 0", LineInReady, WordValid);
        end
        LineIn = l1; tick(); LineInValid = 1'b0;
        exp_w = {l1[15:0], l0[127:112]};
        checks++;
        if (WordValid !== 1'b1 || WordSpill !== 1'b1 || Word !== exp_w) begin
            errors++;
            $display("FAIL spill_word got vld=%b spill=%b word=%h want 1 1 %h",
                     WordValid, WordSpill, Word, exp_w);
        end
        tick();
        exp_w = l1[47:16];
        checks++;
        if (WordValid !== 1'b1 || WordSpill !== 1'b0 || Word !== exp_w) begin
            errors++;
            $display("FAIL spill_next_word got vld=%b spill=%b word=%h want 1 0 %h",
                     WordValid, WordSpill, Word, exp_w);
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        logic [LINELEN-1:0] l0;
        l0 = rand_line();
        WordReady = 1'b0;
        Start = 1'b1; StartIdx = IDXW'(2); tick(); Start = 1'b0;
        LineIn = l0; LineInValid = 1'b1; tick(); LineInValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (WordValid !== 1'b1 || Word !== l0[63:32] || WordSpill !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d got vld=%b word=%h want 1 %h",
                         k, WordValid, Word, l0[63:32]);
            end
            tick();
        end
        WordReady = 1'b1;
        checks++;
        if (WordValid !== 1'b1 || Word !== l0[63:32]) begin
            errors++;
            $display("FAIL backpressure_release got vld=%b word=%h want 1 %h", WordValid, Word, l0[63:32]);
        end
        tick();
        checks++;
        if (WordValid !== 1'b1 || Word !== l0[95:64]) begin
            errors++;
            $display("FAIL backpressure_next got vld=%b word=%h want 1 %h", WordValid, Word, l0[95:64]);
        end
        tick();
        checks++;
        if (WordValid !== 1'b1 || Word !== l0[127:96]) begin
            errors++;
            $display("FAIL backpressure_last got vld=%b word=%h want 1 %h", WordValid, Word, l0[127:96]);
        end
        go_idle();
    endtask

    task automatic test_stop_spillfill();
        logic [LINELEN-1:0] l0, l2;
        l0 = rand_line(); l2 = rand_line();
        WordReady = 1'b1;
        Start = 1'b1; StartIdx = IDXW'(7); tick(); Start = 1'b0;
        LineIn = l0; LineInValid = 1'b1; tick(); LineInValid = 1'b0;
        tick();
        checks++;
        if (LineInReady !== 1'b1) begin
            errors++;
            $display("FAIL stop_reach_spillfill got rdy=%b want 1", LineInReady);
        end
        LineIn = rand_line(); LineInValid = 1'b1; Stop = 1'b1;
        tick();
        Stop = 1'b0; LineInValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (WordValid !== 1'b0 || LineInReady !== 1'b0) begin
                errors++;
                $display("FAIL stop_idle%0d got vld=%b rdy=%b want 0 0", k, WordValid, LineInReady);
            end
            tick();
        end
        // Start together with Stop stays in IDLE.
        Start = 1'b1; Stop = 1'b1; StartIdx = '0; tick(); Start = 1'b0; Stop = 1'b0;
        checks++;
        if (LineInReady !== 1'b0) begin
            errors++;
            $display("FAIL stop_with_start got rdy=%b want 0", LineInReady);
        end
        Start = 1'b1; StartIdx = '0; tick(); Start = 1'b0;
        LineIn = l2; LineInValid = 1'b1; tick(); LineInValid = 1'b0;
        checks++;
        if (WordValid !== 1'b1 || Word !== l2[31:0] || WordSpill !== 1'b0) begin
            errors++;
            $display("FAIL stop_restart got vld=%b word=%h want 1 %h", WordValid, Word, l2[31:0]);
        end
        go_idle();
    endtask

    task automatic test_reset_spill();
        logic [LINELEN-1:0] l0, l1;
        for (int pass = 0; pass < 2; pass++) begin
            l0 = rand_line(); l1 = rand_line();
            WordReady = 1'b0;
            Start = 1'b1; StartIdx = IDXW'(7); tick(); Start = 1'b0;
            LineIn = l0; LineInValid = 1'b1; tick();
            tick();
            LineIn = l1; tick(); LineInValid = 1'b0;
            checks++;
            if (WordValid !== 1'b1 || WordSpill !== 1'b1 || Word !== {l1[15:0], l0[127:112]}) begin
                errors++;
                $display("FAIL rst_spill_word%0d got vld=%b spill=%b word=%h want 1 1 %h",
                         pass, WordValid, WordSpill, Word, {l1[15:0], l0[127:112]});
            end
            if (pass == 0) begin
                #2 reset_n = 1'b0;
                #1;
                checks++;
                if (WordValid !== 1'b0 || WordSpill !== 1'b0 || LineInReady !== 1'b0 || Word !== '0) begin
                    errors++;
                    $display("FAIL rst_async got vld=%b spill=%b rdy=%b word=%h want all 0",
                             WordValid, WordSpill, LineInReady, Word);
                end
                tick();
                reset_n = 1'b1;
                tick();
                checks++;
                if (WordValid !== 1'b0 || LineInReady !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_idle got vld=%b rdy=%b want 0 0", WordValid, LineInReady);
                end
            end else begin
                go_idle();
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [LINELEN-1:0] l0;
        l0 = rand_line();
        WordReady = 1'b1;
        Start = 1'b1; StartIdx = '0; tick(); Start = 1'b0;
        LineIn = l0; LineInValid = 1'b1; tick(); LineInValid = 1'b0;
        Start = 1'b1; StartIdx = IDXW'(5);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (WordValid !== 1'b1 || Word !== l0[k*WORDLEN +: WORDLEN]) begin
                errors++;
                $display("FAIL start_ignored_word%0d got vld=%b word=%h want 1 %h",
                         k, WordValid, Word, l0[k*WORDLEN +: WORDLEN]);
            end
            tick();
        end
        Start = 1'b0;
        checks++;
        if (LineInReady !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_refill got rdy=%b want 1", LineInReady);
        end
        go_idle();
    endtask

    // Reference: the output is the concatenated line stream cut into
    // STEP-granule words, starting StartIdx granules into the first line.
    task automatic test_random_stream();
        logic [MUXINTERVAL-1:0] gq[$];
        logic [WORDLEN-1:0]     ew;
        logic                   es;
        logic                   acc, hs;
        int sidx, pos, skip, words, nwords, cyc;
        for (int iter = 0; iter < 20; iter++) begin
            sidx = $urandom_range(0, SLOTS-1);
            WordReady = 1'b0; LineInValid = 1'b0;
            Start = 1'b1; StartIdx = IDXW'(sidx); tick(); Start = 1'b0;
            gq.delete();
            pos = sidx; skip = sidx; words = 0; cyc = 0;
            nwords = $urandom_range(3, 12);
            while (words < nwords && cyc < 400) begin
                checks++;
                if (WordValid !== (gq.size() >= STEP)) begin
                    errors++;
                    $display("FAIL rand_valid it%0d cyc%0d got %b want %b",
                             iter, cyc, WordValid, (gq.size() >= STEP));
                end
                if (gq.size() >= STEP) begin
                    for (int i = 0; i < STEP; i++) ew[i*MUXINTERVAL +: MUXINTERVAL] = gq[i];
                    es = (pos + STEP > SLOTS);
                    checks++;
                    if (Word !== ew || WordSpill !== es) begin
                        errors++;
                        $display("FAIL rand_word it%0d w%0d got %h/%b want %h/%b",
                                 iter, words, Word, WordSpill, ew, es);
                    end
                end
                if (LineInReady === 1'b1) begin
                    checks++;
                    if (gq.size() >= STEP) begin
                        errors++;
                        $display("FAIL rand_ready it%0d got rdy=1 want 0 (have %0d granules)",
                                 iter, gq.size());
                    end
                end
                LineInValid = ($urandom_range(0, 9) < 7);
                LineIn      = rand_line();
                WordReady   = ($urandom_range(0, 9) < 7);
                Start       = ($urandom_range(0, 7) == 0);
                StartIdx    = IDXW'($urandom_range(0, SLOTS-1));
                acc = LineInReady && LineInValid;
                hs  = (gq.size() >= STEP) && WordReady;
                if (hs) begin
                    for (int i = 0; i < STEP; i++) void'(gq.pop_front());
                    pos = (pos + STEP) % SLOTS;
                    words++;
                end
                if (acc) begin
                    for (int g = skip; g < SLOTS; g++) gq.push_back(LineIn[g*MUXINTERVAL +: MUXINTERVAL]);
                    skip = 0;
                end
                tick();
                cyc++;
            end
            if (cyc >= 400) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout it%0d got %0d words want %0d", iter, words, nwords);
            end
            Start = 1'b0;
            go_idle();
            checks++;
            if (WordValid !== 1'b0 || LineInReady !== 1'b0) begin
                errors++;
                $display("FAIL rand_stop it%0d got vld=%b rdy=%b want 0 0", iter, WordValid, LineInReady);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_aligned();
        test_spill();
        test_backpressure();
        test_stop_spillfill();
        test_reset_spill();
        test_start_ignored();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
